// File: rtl/comparator_monitor_pkg.sv
// Shared register map and bit positions for the comparator monitor.
package comparator_monitor_pkg;

    typedef enum logic [1:0] {
        REG_CTRL        = 2'd0,
        REG_STATUS      = 2'd1,
        REG_RISE_CNT    = 2'd2,
        REG_LAST_PERIOD = 2'd3
    } reg_addr_e;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_RISE_IE = 1;
    localparam int unsigned CTRL_FALL_IE = 2;
    localparam int unsigned CTRL_CLR     = 3;

    localparam int unsigned STAT_LEVEL   = 0;
    localparam int unsigned STAT_RISE_P  = 1;
    localparam int unsigned STAT_FALL_P  = 2;

endpackage

// File: rtl/comparator_monitor_if.sv
// Wishbone classic slave bus bundle for the comparator monitor.
interface comparator_monitor_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/comp_sync_filter.sv
// Two-flop synchroniser plus persistence filter for the raw comparator output.
module comp_sync_filter #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic comp_in,
    output logic filt,
    output logic rise,
    output logic fall
);

    localparam int unsigned FCNT_W = $clog2(FILT_LEN + 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_LEN - 1);

    logic              s1;
    logic              s2;
    logic [FCNT_W-1:0] fcnt;
    logic              settle;

    // Edge strobes fire on the same clock edge that updates filt.
    assign settle = (s2 != filt) && (fcnt == FCNT_LAST);
    assign rise   = settle & s2;
    assign fall   = settle & ~s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            filt <= 1'b0;
            fcnt <= '0;
        end else begin
            s1 <= comp_in;
            s2 <= s1;
            if (s2 == filt) begin
                fcnt <= '0;
            end else if (fcnt == FCNT_LAST) begin
                filt <= s2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + FCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/comparator_monitor.sv
// Comparator receive monitor: filtered level, rise counter, period meter,
// Wishbone register file and maskable level interrupt.
module comparator_monitor
    import comparator_monitor_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 comp_in,
    comparator_monitor_if.slave  wbs,
    output logic                 comp_filt_o,
    output logic                 irq_o
);

    logic             rise;
    logic             fall;
    logic             req;
    logic             wr;
    reg_addr_e        addr;
    logic             ctrl_wr;
    logic             stat_wr;
    logic             clr;
    logic             ev_rise;
    logic             ev_fall;
    logic [31:0]      rdata;

    logic             en;
    logic             rise_ie;
    logic             fall_ie;
    logic             rise_p;
    logic             fall_p;
    logic             armed;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] last_period;
    logic [CNT_W-1:0] run_cnt;

    logic             unused_bits;
    assign unused_bits = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[31:4], wbs.wbs_adr_i[1:0],
                           wbs.wbs_dat_i[31:4]};

    comp_sync_filter #(
        .FILT_LEN(FILT_LEN)
    ) u_sync_filter (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .comp_in (comp_in),
        .filt    (comp_filt_o),
        .rise    (rise),
        .fall    (fall)
    );

    assign req     = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~wbs.wbs_ack_o;
    assign wr      = req & wbs.wbs_we_i;
    assign addr    = reg_addr_e'(wbs.wbs_adr_i[3:2]);
    assign ctrl_wr = wr && (addr == REG_CTRL);
    assign stat_wr = wr && (addr == REG_STATUS);
    assign clr     = ctrl_wr & wbs.wbs_dat_i[CTRL_CLR];
    assign ev_rise = rise & en;
    assign ev_fall = fall & en;

    always_comb begin
        rdata = '0;
        unique case (addr)
            REG_CTRL: begin
                rdata[CTRL_EN]      = en;
                rdata[CTRL_RISE_IE] = rise_ie;
                rdata[CTRL_FALL_IE] = fall_ie;
            end
            REG_STATUS: begin
                rdata[STAT_LEVEL]  = comp_filt_o;
                rdata[STAT_RISE_P] = rise_p;
                rdata[STAT_FALL_P] = fall_p;
            end
            REG_RISE_CNT:    rdata[CNT_W-1:0] = rise_cnt;
            REG_LAST_PERIOD: rdata[CNT_W-1:0] = last_period;
            default:         rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= '0;
        end else begin
            wbs.wbs_ack_o <= req;
            wbs.wbs_dat_o <= (req & ~wbs.wbs_we_i) ? rdata : '0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en      <= 1'b0;
            rise_ie <= 1'b0;
            fall_ie <= 1'b0;
            rise_p  <= 1'b0;
            fall_p  <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en      <= wbs.wbs_dat_i[CTRL_EN];
                rise_ie <= wbs.wbs_dat_i[CTRL_RISE_IE];
                fall_ie <= wbs.wbs_dat_i[CTRL_FALL_IE];
            end
            // A new edge overrides a same-cycle write-1-to-clear.
            rise_p <= ev_rise | (rise_p & ~(stat_wr & wbs.wbs_dat_i[STAT_RISE_P]));
            fall_p <= ev_fall | (fall_p & ~(stat_wr & wbs.wbs_dat_i[STAT_FALL_P]));
            irq_o  <= (rise_p & rise_ie) | (fall_p & fall_ie);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rise_cnt    <= '0;
            last_period <= '0;
            run_cnt     <= '0;
            armed       <= 1'b0;
        end else if (clr) begin
            rise_cnt    <= '0;
            last_period <= '0;
            run_cnt     <= '0;
            armed       <= 1'b0;
        end else if (en) begin
            if (ev_rise) begin
                if (rise_cnt != '1) begin
                    rise_cnt <= rise_cnt + CNT_W'(1);
                end
                if (armed) begin
                    last_period <= run_cnt;
                end
                armed   <= 1'b1;
                run_cnt <= CNT_W'(1);
            end else if (run_cnt != '1) begin
                run_cnt <= run_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_comparator_monitor.sv
// Directed self-checking bench for comparator_monitor (FILT_LEN=4, CNT_W=8).
module tb_comparator_monitor;
    import comparator_monitor_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic comp_in = 1'b0;
    logic comp_filt;
    logic irq;
    int   checks = 0;
    int   errors = 0;

    comparator_monitor_if bus();

    comparator_monitor #(
        .FILT_LEN(4),
        .CNT_W   (8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .comp_in     (comp_in),
        .wbs         (bus.slave),
        .comp_filt_o (comp_filt),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_xfer(input logic we, input logic [1:0] a, input logic [31:0] wd,
                            output logic [31:0] rd);
        bit got = 1'b0;
        rd = '0;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = 4'hf;
        bus.wbs_adr_i = {28'd0, a, 2'b00};
        bus.wbs_dat_i = wd;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (bus.wbs_ack_o === 1'b1) begin
                got = 1'b1;
                rd  = bus.wbs_dat_o;
            end
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout addr=%0d: no ack within 8 cycles, required ack", a);
            rd = 'x;
        end
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        bus_xfer(1'b0, a, 32'd0, d);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xfer(1'b1, a, d, dummy);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        wr_reg(REG_CTRL, 32'h3);
        comp_in = 1'b1;
        ticks(8);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL reset_pre_irq got=%b exp=1", irq); end
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = {28'd0, 2'd1, 2'b00};
        tick();
        checks++;
        if (bus.wbs_ack_o !== 1'b1) begin errors++; $display("FAIL reset_pre_ack got=%b exp=1", bus.wbs_ack_o); end
        rst = 1'b1;
        comp_in = 1'b0;
        #1;
        checks++;
        if ({bus.wbs_ack_o, irq, comp_filt} !== 3'b000 || bus.wbs_dat_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_async ack=%b irq=%b filt=%b dat=%h exp all 0",
                     bus.wbs_ack_o, irq, comp_filt, bus.wbs_dat_o);
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int r = 0; r < 4; r++) begin
            rd_reg(2'(r), d);
            checks++;
            if (d !== 32'd0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=0", r, d); end
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        bit stayed_low = 1'b1;
        wr_reg(REG_CTRL, 32'h1);
        comp_in = 1'b1;
        ticks(3);
        comp_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (comp_filt !== 1'b0) stayed_low = 1'b0;
        end
        checks++;
        if (!stayed_low) begin errors++; $display("FAIL glitch_3cyc_filt went high, exp stay 0"); end
        rd_reg(REG_RISE_CNT, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL glitch_3cyc_cnt got=%0d exp=0", d); end

        comp_in = 1'b1;
        ticks(5);
        checks++;
        if (comp_filt !== 1'b0) begin errors++; $display("FAIL glitch_6cyc_early got=%b exp=0", comp_filt); end
        tick();
        checks++;
        if (comp_filt !== 1'b1) begin errors++; $display("FAIL glitch_6cyc_edge6 got=%b exp=1", comp_filt); end
        comp_in = 1'b0;
        ticks(10);
        rd_reg(REG_RISE_CNT, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL glitch_6cyc_cnt got=%0d exp=1", d); end
        rd_reg(REG_STATUS, d);
        checks++;
        if (d !== 32'h6) begin errors++; $display("FAIL glitch_status got=%h exp=6", d); end
    endtask

    task automatic test_period();
        logic [31:0] d;
        wr_reg(REG_STATUS, 32'h6);
        wr_reg(REG_CTRL, 32'h9);
        wr_reg(REG_CTRL, 32'h3);
        for (int p = 0; p < 5; p++) begin
            comp_in = 1'b1; ticks(20);
            comp_in = 1'b0; ticks(20);
        end
        rd_reg(REG_RISE_CNT, d);
        checks++;
        if (d !== 32'd5) begin errors++; $display("FAIL period_cnt got=%0d exp=5", d); end
        rd_reg(REG_LAST_PERIOD, d);
        checks++;
        if (d !== 32'd40) begin errors++; $display("FAIL period_last got=%0d exp=40", d); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL period_irq got=%b exp=1", irq); end
        wr_reg(REG_STATUS, 32'h2);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL period_irq_reg got=%b exp=1", irq); end
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL period_irq_clr got=%b exp=0", irq); end
        rd_reg(REG_STATUS, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL period_status got=%h exp=4", d); end
    endtask

    task automatic test_collisions();
        logic [31:0] d;
        comp_in = 1'b1;
        ticks(5);
        wr_reg(REG_STATUS, 32'h2);
        rd_reg(REG_STATUS, d);
        checks++;
        if (d !== 32'h7) begin errors++; $display("FAIL coll_w1c_status got=%h exp=7", d); end

        comp_in = 1'b0;
        ticks(12);
        wr_reg(REG_STATUS, 32'h6);
        comp_in = 1'b1;
        ticks(5);
        wr_reg(REG_CTRL, 32'h9);
        rd_reg(REG_RISE_CNT, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL coll_clr_cnt got=%0d exp=0", d); end
        rd_reg(REG_STATUS, d);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL coll_clr_status got=%h exp=3", d); end
        comp_in = 1'b0; ticks(20);
        comp_in = 1'b1; ticks(20);
        rd_reg(REG_LAST_PERIOD, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL coll_clr_last got=%0d exp=0", d); end
        rd_reg(REG_RISE_CNT, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL coll_clr_cnt2 got=%0d exp=1", d); end
    endtask

    task automatic test_gating();
        logic [31:0] d;
        comp_in = 1'b0;
        ticks(20);
        wr_reg(REG_CTRL, 32'h9);
        wr_reg(REG_CTRL, 32'h1);
        for (int p = 0; p < 2; p++) begin
            comp_in = 1'b1; ticks(20);
            comp_in = 1'b0; ticks(20);
        end
        wr_reg(REG_STATUS, 32'h6);
        wr_reg(REG_CTRL, 32'h0);
        for (int p = 0; p < 10; p++) begin
            comp_in = 1'b1;
            ticks(12);
            rd_reg(REG_STATUS, d);
            checks++;
            if (d !== 32'h1) begin errors++; $display("FAIL gate_level_hi[%0d] got=%h exp=1", p, d); end
            ticks(7);
            comp_in = 1'b0;
            ticks(12);
            rd_reg(REG_STATUS, d);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL gate_level_lo[%0d] got=%h exp=0", p, d); end
            ticks(7);
        end
        rd_reg(REG_RISE_CNT, d);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL gate_cnt got=%0d exp=2", d); end
        rd_reg(REG_LAST_PERIOD, d);
        checks++;
        if (d !== 32'd40) begin errors++; $display("FAIL gate_last got=%0d exp=40", d); end
    endtask

    task automatic test_saturation();
        logic [31:0] d;
        wr_reg(REG_CTRL, 32'h9);
        wr_reg(REG_CTRL, 32'h1);
        for (int p = 0; p < 300; p++) begin
            comp_in = 1'b1; ticks(5);
            comp_in = 1'b0; ticks(5);
        end
        ticks(10);
        rd_reg(REG_RISE_CNT, d);
        checks++;
        if (d !== 32'd255) begin errors++; $display("FAIL sat_cnt got=%0d exp=255", d); end
        rd_reg(REG_LAST_PERIOD, d);
        checks++;
        if (d !== 32'd10) begin errors++; $display("FAIL sat_last got=%0d exp=10", d); end
    endtask

    initial begin
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        ticks(3);
        rst = 1'b0;
        tick();
        test_reset();
        test_glitch();
        test_period();
        test_collisions();
        test_gating();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
